// File: rtl/ecg_pkg.sv
// ---------------------------------------------------------------------------
// ecg_pkg
// Shared definitions for the token projection datapath:
//   - default matrix geometry (N_TOK_DEF token rows, DIM_DEF embedding width)
//   - fixed-point widths: Q4.4 operands, Q8.8 products, Q12.8 accumulator
//   - controller state encoding (IDLE / MAC / STORE)
// No ports; imported by linear_proj and sat_q44.
// ---------------------------------------------------------------------------
package ecg_pkg;

  localparam int N_TOK_DEF  = 16;
  localparam int DIM_DEF    = 16;

  localparam int Q44_W      = 8;   // Q4.4 operand / result width
  localparam int Q88_W      = 16;  // Q8.8 product width
  localparam int ACC_W      = 20;  // Q12.8 accumulator width
  localparam int FRAC_SHIFT = 4;   // Q8.8 -> Q4.4 realignment

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    STORE = 2'd2
  } state_t;

endpackage

// File: rtl/sat_q44.sv
// ---------------------------------------------------------------------------
// sat_q44
// Combinational narrowing of a biased Q12.8 sum to a Q4.4 byte: arithmetic
// shift right by FRAC_SHIFT, then either saturate to [-128,127] or wrap.
// Build option: define LINEAR_PROJ_SAT_EN to select saturation; otherwise
// the low byte of the shifted sum is taken (two's-complement wrap).
// Ports:
//   sum_i  in  signed [IN_W-1:0]  biased accumulator value (Q.8 format)
//   q_o    out signed [7:0]       narrowed Q4.4 result
// ---------------------------------------------------------------------------
module sat_q44
  import ecg_pkg::*;
#(
  parameter int IN_W = ACC_W + 1
) (
  input  logic signed [IN_W-1:0]  sum_i,
  output logic signed [Q44_W-1:0] q_o
);

  localparam int SH_W = IN_W - FRAC_SHIFT;
  localparam logic signed [SH_W-1:0] Q_MAX = SH_W'(127);
  localparam logic signed [SH_W-1:0] Q_MIN = SH_W'(-128);

  logic signed [SH_W-1:0] shifted_s;
  logic                   unused_s;

  // Dropping the fraction bits is the arithmetic shift; the sign stays on top.
  assign shifted_s = sum_i[IN_W-1:FRAC_SHIFT];
  assign unused_s  = ^{sum_i[FRAC_SHIFT-1:0], shifted_s};

`ifdef LINEAR_PROJ_SAT_EN
  // Clamp out-of-range sums to the Q4.4 extremes.
  always_comb begin
    q_o = shifted_s[Q44_W-1:0];
    if (shifted_s > Q_MAX) begin
      q_o = 8'h7F;
    end else if (shifted_s < Q_MIN) begin
      q_o = 8'h80;
    end else begin
      q_o = shifted_s[Q44_W-1:0];
    end
  end
`else
  // Keep the low byte; out-of-range sums wrap.
  always_comb begin
    q_o = shifted_s[Q44_W-1:0];
  end
`endif

endmodule

// File: rtl/linear_proj.sv
// ---------------------------------------------------------------------------
// linear_proj
// Projects an N_TOK x DIM Q4.4 token matrix through a DIM x DIM Q4.4 weight
// matrix plus per-column bias, one multiply-accumulate per cycle. Each output
// element takes DIM MAC cycles followed by one STORE cycle.
// Build option: LINEAR_PROJ_SAT_EN (saturating narrowing, see sat_q44).
// Ports:
//   clk     in   rising-edge clock
//   rst     in   synchronous active-high reset
//   start   in   one-cycle run request (ignored while busy)
//   tokens  in   [N_TOK][DIM] signed Q4.4, held stable while busy
//   wt      in   [DIM*DIM] signed Q4.4, element (k,c) at k*DIM+c
//   bias    in   [DIM] signed Q4.4 per-column bias
//   result  out  [N_TOK][DIM] signed Q4.4 projected matrix
//   busy    out  high while state is not IDLE
//   done    out  one-cycle pulse after the last element is written
// ---------------------------------------------------------------------------
module linear_proj
  import ecg_pkg::*;
#(
  parameter int N_TOK = N_TOK_DEF,
  parameter int DIM   = DIM_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [Q44_W-1:0] tokens [0:N_TOK-1][0:DIM-1],
  input  logic signed [Q44_W-1:0] wt     [0:DIM*DIM-1],
  input  logic signed [Q44_W-1:0] bias   [0:DIM-1],
  output logic signed [Q44_W-1:0] result [0:N_TOK-1][0:DIM-1],
  output logic                    busy,
  output logic                    done
);

  localparam int RW    = (N_TOK > 1) ? $clog2(N_TOK) : 1;
  localparam int CW    = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int WW    = (DIM > 1) ? $clog2(DIM * DIM) : 1;
  localparam int SUM_W = ACC_W + 1;

  localparam logic [RW-1:0] R_LAST = RW'(N_TOK - 1);
  localparam logic [CW-1:0] C_LAST = CW'(DIM - 1);

  state_t                   state_q, state_d;
  logic [RW-1:0]            r_q, r_d;
  logic [CW-1:0]            c_q, c_d;
  logic [CW-1:0]            k_q, k_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     done_q, done_d;

  logic [WW-1:0]            wt_idx_s;
  logic signed [Q88_W-1:0]  prod_s;
  logic signed [SUM_W-1:0]  sum_s;
  logic signed [Q44_W-1:0]  q_s;

  // Operand selection, Q8.8 product and biased sum for the current element.
  always_comb begin
    wt_idx_s = WW'(k_q) * WW'(DIM) + WW'(c_q);
    prod_s   = tokens[r_q][k_q] * wt[wt_idx_s];
    // Bias is Q4.4; shifting left by 4 aligns it with the Q.8 accumulator.
    sum_s    = {acc_q[ACC_W-1], acc_q}
             + {{(SUM_W-Q44_W-FRAC_SHIFT){bias[c_q][Q44_W-1]}}, bias[c_q],
                {FRAC_SHIFT{1'b0}}};
  end

  sat_q44 #(
    .IN_W (SUM_W)
  ) u_sat (
    .sum_i (sum_s),
    .q_o   (q_s)
  );

  // Controller next-state, counters and accumulator.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    k_d     = k_q;
    acc_d   = acc_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = MAC;
          r_d     = '0;
          c_d     = '0;
          k_d     = '0;
          acc_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      MAC: begin
        acc_d = acc_q + {{(ACC_W-Q88_W){prod_s[Q88_W-1]}}, prod_s};
        if (k_q == C_LAST) begin
          state_d = STORE;
          k_d     = '0;
        end else begin
          k_d = k_q + CW'(1);
        end
      end
      STORE: begin
        acc_d = '0;
        if (c_q == C_LAST) begin
          c_d = '0;
          if (r_q == R_LAST) begin
            state_d = IDLE;
            r_d     = '0;
            done_d  = 1'b1;
          end else begin
            state_d = MAC;
            r_d     = r_q + RW'(1);
          end
        end else begin
          state_d = MAC;
          c_d     = c_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      c_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
    end
  end

  // Result matrix: written once per element in STORE, otherwise held.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N_TOK; r++) begin
        for (int c = 0; c < DIM; c++) begin
          result[r][c] <= '0;
        end
      end
    end else if (state_q == STORE) begin
      result[r_q][c_q] <= q_s;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_linear_proj.sv
// ---------------------------------------------------------------------------
// tb_linear_proj
// Self-checking bench for linear_proj at default geometry. Expected results
// are pushed to a scoreboard queue before each run and compared element by
// element after done. Honours LINEAR_PROJ_SAT_EN for the overflow case.
// ---------------------------------------------------------------------------
module tb_linear_proj;

  localparam int N_TOK   = 16;
  localparam int DIM     = 16;
  localparam int RUN_LEN = N_TOK * DIM * (DIM + 1);
  localparam int BOUND   = RUN_LEN + 200;

  logic              clk;
  logic              rst;
  logic              start;
  logic signed [7:0] tokens [N_TOK][DIM];
  logic signed [7:0] wt     [DIM*DIM];
  logic signed [7:0] bias   [DIM];
  logic signed [7:0] result [N_TOK][DIM];
  logic              busy;
  logic              done;

  logic [7:0] exp_q[$];
  int         total;
  int         bad;

  linear_proj #(
    .N_TOK (N_TOK),
    .DIM   (DIM)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .tokens (tokens),
    .wt     (wt),
    .bias   (bias),
    .result (result),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference for one element, integer arithmetic.
  function automatic logic [7:0] model_elem(int r, int c);
    int s;
    s = int'(bias[c]) * 16;
    for (int k = 0; k < DIM; k++) begin
      s = s + int'(tokens[r][k]) * int'(wt[k*DIM+c]);
    end
    s = s >>> 4;
`ifdef LINEAR_PROJ_SAT_EN
    if (s > 127) s = 127;
    else if (s < -128) s = -128;
`endif
    return s[7:0];
  endfunction

  task automatic set_identity_wt();
    for (int k = 0; k < DIM; k++)
      for (int c = 0; c < DIM; c++)
        wt[k*DIM+c] = (k == c) ? 8'sh10 : 8'sh00;
  endtask

  // Pop one expected value per element and compare with the DUT matrix.
  task automatic scoreboard_drain(input string name);
    logic [7:0] e;
    for (int r = 0; r < N_TOK; r++) begin
      for (int c = 0; c < DIM; c++) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL %s: scoreboard empty at [%0d][%0d]", name, r, c);
        end else begin
          e = exp_q.pop_front();
          if (result[r][c] !== e) begin
            bad++;
            $display("FAIL %s: result[%0d][%0d] got %h want %h", name, r, c, result[r][c], e);
          end
        end
      end
    end
  endtask

  // Pulse start, optionally re-pulse it mid-run, time done, then drain.
  task automatic run_projection(input string name, input int restart_at);
    int first_done;
    int pulses;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;   // this edge (edge 0) sampled start
    start = 1'b0;
    first_done = -1;
    pulses = 0;
    for (int n = 1; n <= BOUND; n++) begin
      start = (n == restart_at) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        if (first_done < 0) first_done = n;
      end
      if (first_done >= 0 && n >= first_done + 4) break;
    end
    start = 1'b0;
    total++;
    if (first_done !== RUN_LEN) begin
      bad++;
      $display("FAIL %s_done_edge: got %0d want %0d", name, first_done, RUN_LEN);
    end
    total++;
    if (pulses !== 1) begin
      bad++;
      $display("FAIL %s_done_count: got %0d want 1", name, pulses);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_busy_after: got %b want 0", name, busy);
    end
    scoreboard_drain(name);
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL reset_done: got %b want 0", done);
    end
    for (int i = 0; i < N_TOK*DIM; i++) exp_q.push_back(8'h00);
    scoreboard_drain("reset");
    rst   = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_bias_only();
    for (int r = 0; r < N_TOK; r++)
      for (int k = 0; k < DIM; k++) tokens[r][k] = 8'sh00;
    for (int i = 0; i < DIM*DIM; i++) wt[i] = 8'($urandom);
    for (int c = 0; c < DIM; c++) bias[c] = 8'sh10;
    for (int i = 0; i < N_TOK*DIM; i++) exp_q.push_back(8'h10);
    run_projection("bias_only", 0);
  endtask

  task automatic test_identity();
    for (int r = 0; r < N_TOK; r++)
      for (int k = 0; k < DIM; k++) tokens[r][k] = 8'($urandom);
    set_identity_wt();
    for (int c = 0; c < DIM; c++) bias[c] = 8'sh00;
    for (int r = 0; r < N_TOK; r++)
      for (int c = 0; c < DIM; c++) exp_q.push_back(tokens[r][c]);
    run_projection("identity", 0);
  endtask

  task automatic test_negative();
    for (int r = 0; r < N_TOK; r++)
      for (int k = 0; k < DIM; k++) tokens[r][k] = 8'shF0;
    set_identity_wt();
    for (int c = 0; c < DIM; c++) bias[c] = 8'sh08;
    for (int i = 0; i < N_TOK*DIM; i++) exp_q.push_back(8'hF8);
    run_projection("negative", 0);
  endtask

  task automatic test_overflow();
    for (int r = 0; r < N_TOK; r++)
      for (int k = 0; k < DIM; k++) tokens[r][k] = 8'sh7F;
    for (int i = 0; i < DIM*DIM; i++) wt[i] = 8'sh7F;
    for (int c = 0; c < DIM; c++) bias[c] = 8'sh00;
`ifdef LINEAR_PROJ_SAT_EN
    for (int i = 0; i < N_TOK*DIM; i++) exp_q.push_back(8'h7F);
`else
    for (int i = 0; i < N_TOK*DIM; i++) exp_q.push_back(8'h01);
`endif
    run_projection("overflow", 0);
  endtask

  task automatic test_random();
    for (int r = 0; r < N_TOK; r++)
      for (int k = 0; k < DIM; k++) tokens[r][k] = 8'($urandom);
    for (int i = 0; i < DIM*DIM; i++) wt[i] = 8'($urandom);
    for (int c = 0; c < DIM; c++) bias[c] = 8'($urandom);
    for (int r = 0; r < N_TOK; r++)
      for (int c = 0; c < DIM; c++) exp_q.push_back(model_elem(r, c));
    run_projection("random", 0);
  endtask

  task automatic test_restart_ignored();
    for (int r = 0; r < N_TOK; r++)
      for (int k = 0; k < DIM; k++) tokens[r][k] = 8'($urandom);
    for (int i = 0; i < DIM*DIM; i++) wt[i] = 8'($urandom_range(0, 31) - 16);
    for (int c = 0; c < DIM; c++) bias[c] = 8'($urandom);
    for (int r = 0; r < N_TOK; r++)
      for (int c = 0; c < DIM; c++) exp_q.push_back(model_elem(r, c));
    run_projection("restart", 100);
  endtask

  task automatic test_reset_midrun();
    int pulses;
    for (int r = 0; r < N_TOK; r++)
      for (int k = 0; k < DIM; k++) tokens[r][k] = 8'($urandom);
    set_identity_wt();
    for (int c = 0; c < DIM; c++) bias[c] = 8'sh00;
    pulses = 0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n < 2000; n++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    rst = 1'b1;
    @(posedge clk); #1;   // edge 2000 applies reset
    rst = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL midrun_busy: got %b want 0", busy);
    end
    if (done) pulses++;
    for (int i = 0; i < N_TOK*DIM; i++) exp_q.push_back(8'h00);
    scoreboard_drain("midrun_zero");
    for (int n = 2001; n <= RUN_LEN + 50; n++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    total++;
    if (pulses !== 0) begin
      bad++;
      $display("FAIL midrun_no_done: got %0d pulses want 0", pulses);
    end
    for (int r = 0; r < N_TOK; r++)
      for (int c = 0; c < DIM; c++) exp_q.push_back(tokens[r][c]);
    run_projection("after_reset", 0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    start = 1'b0;
    for (int r = 0; r < N_TOK; r++)
      for (int k = 0; k < DIM; k++) tokens[r][k] = 8'sh00;
    for (int i = 0; i < DIM*DIM; i++) wt[i] = 8'sh00;
    for (int c = 0; c < DIM; c++) bias[c] = 8'sh00;
    test_reset();
    test_bias_only();
    test_identity();
    test_negative();
    test_overflow();
    test_random();
    test_restart_ignored();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/linear_proj.md
LINEAR_PROJ -- requirements
Module: linear_proj

Interface
REQ-001 SHALL have parameter N_TOK, default 16, meaning the number of token rows in the embedded matrix.
REQ-002 SHALL have parameter DIM, default 16, meaning the embedding width, which is also the projection input and output width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: single-cycle request to begin a projection.
REQ-006 SHALL have port tokens, input, signed 8 bit [0:N_TOK-1][0:DIM-1]: the Q4.4 embedded-token matrix produced by the embedding stage.
REQ-007 SHALL have port wt, input, signed 8 bit [0:DIM*DIM-1]: Q4.4 weights, row-major, with element (k,c) at index k*DIM+c.
REQ-008 SHALL have port bias, input, signed 8 bit [0:DIM-1]: Q4.4 per-column bias.
REQ-009 SHALL have port result, output, signed 8 bit [0:N_TOK-1][0:DIM-1]: the Q4.4 projected matrix.
REQ-010 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-011 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-012 SHALL compute result[r][c] = bias[c] + sum over k of tokens[r][k]*wt[k*DIM+c], using one multiply-accumulate per cycle.
REQ-013 SHALL implement states IDLE, MAC and STORE: IDLE goes to MAC when start is high; MAC goes to STORE when k==DIM-1; STORE goes to MAC, or to IDLE after element (N_TOK-1,DIM-1).
REQ-014 SHALL use row counter r, column counter c and inner counter k, all cleared on entry from IDLE; k increments in MAC; c increments in STORE, wrapping to 0 with r incrementing.
REQ-015 SHALL form each product as a 16-bit signed Q8.8 value and accumulate it into a 20-bit signed Q12.8 accumulator with no overflow possible.
REQ-016 SHALL, in STORE, compute acc + (sign-extended bias[c] << 4), arithmetically shift the sum right 4, narrow it to 8 bits per REQ-024/025, write it to result[r][c], and clear the accumulator.
REQ-017 SHALL spend 17 cycles per element, so that done is high during exactly the cycle following the edge that is N_TOK*DIM*(DIM+1) edges (4352 at defaults) after the edge that sampled start.
REQ-018 SHALL assert done on the same edge that writes the last element and that returns the state to IDLE; done SHALL be low otherwise.
REQ-019 SHALL ignore start while busy is high, with no restart and no queuing.
REQ-020 SHALL require tokens, wt and bias to be held stable while busy; they are sampled live, with no input capture.
REQ-021 SHALL hold result unchanged between STORE writes and after completion, until overwritten by the next run.

Reset
REQ-022 SHALL, when rst is high at a clock edge, set state to IDLE and set r, c, k, the accumulator, all result elements, done and busy to 0, overriding start.
REQ-023 SHALL, on reset mid-run, abandon the run, produce no done pulse, and zero the partially written results.

Configuration
REQ-024 SHALL, with LINEAR_PROJ_SAT_EN defined, saturate the shifted sum to [-128,127] (0x80..0x7F).
REQ-025 SHALL, without LINEAR_PROJ_SAT_EN, take bits [7:0] of the shifted sum (two's-complement wrap); no other behaviour differs.

Structure
REQ-026 SHALL take N_TOK/DIM defaults, the state enum (IDLE/MAC/STORE) and the Q4.4/Q8.8 width constants from a shared package ecg_pkg.
REQ-027 SHALL place the narrowing (shift, then saturate or wrap) in one sub-module sat_q44, which is combinational and contains the macro switch.

Verification
REQ-028 SHALL verify: tokens all 0x00, bias all 0x10 -> every result 0x10; done after 4352 edges.
REQ-029 SHALL verify: wt identity (0x10 where k==c, else 0), bias 0, random tokens -> result equals tokens bit-exactly.
REQ-030 SHALL verify: tokens all 0xF0, wt identity, bias 0x08 -> every result 0xF8.
REQ-031 SHALL verify: tokens and wt all 0x7F, bias 0 -> every result 0x7F with LINEAR_PROJ_SAT_EN defined, 0x01 without it.
REQ-032 SHALL verify: start re-pulsed at cycle 100 of a run -> exactly one done, at edge 4352, and results unaffected.
REQ-033 SHALL verify: rst at cycle 2000 -> busy 0 and all results 0 next cycle, no done; a fresh start completes normally.
